// File: rtl/pwm_edge_capture.sv
// Timestamped PWM transition capture with a show-ahead record FIFO.
// One slot is held back during a capture so its final record can always be stored.
module pwm_edge_capture #(
    parameter int CHANNELS = 1,
    parameter int TS_WIDTH = 24,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CHANNELS-1:0]      pwm_in,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [TS_WIDTH-1:0]      cap_len,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TS_WIDTH-1:0]      rd_ts,
    output logic [CHANNELS-1:0]      rd_level,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = TS_WIDTH + CHANNELS + 1;
    localparam logic [AW:0] CNT_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_RESERVE = (AW+1)'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] len_reg;
    logic [TS_WIDTH-1:0] next_ts;
    logic [TS_WIDTH-1:0] wr_ts;
    logic [CHANNELS-1:0] prev;
    logic                want_write;
    logic                want_last;
    logic                finish;
    logic                fits;
    logic                push;
    logic                pop;
    logic                drop;
    logic [RW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    always_comb begin
        want_write = 1'b0;
        want_last  = 1'b0;
        finish     = 1'b0;
        wr_ts      = '0;
        next_ts    = ts + 1'b1;
        case (state)
            IDLE: begin
                if (arm) begin
                    want_write = 1'b1;
                    want_last  = (cap_len == '0);
                    finish     = (cap_len == '0);
                end
            end
            RUN: begin
                wr_ts = next_ts;
                if (next_ts == len_reg || stop) begin
                    want_write = 1'b1;
                    want_last  = 1'b1;
                    finish     = 1'b1;
                end else if (pwm_in != prev) begin
                    want_write = 1'b1;
                end
            end
            default: ;
        endcase
        // Space is judged on the occupancy at cycle start; a same-cycle pop does not help.
        fits = want_last ? (count < CNT_FULL) : (count < CNT_RESERVE);
        push = want_write & fits;
        drop = want_write & ~fits;
    end

    assign pop = rd_valid & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ts       <= '0;
            len_reg  <= '0;
            prev     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            case (state)
                IDLE: begin
                    if (arm) begin
                        len_reg  <= cap_len;
                        ts       <= '0;
                        prev     <= pwm_in;
                        overflow <= drop;
                        if (cap_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    ts       <= next_ts;
                    prev     <= pwm_in;
                    overflow <= overflow | drop;
                    if (finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_ts, pwm_in, want_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_valid                    = (count != '0);
    assign {rd_ts, rd_level, rd_last}  = mem[rd_ptr];
    assign fifo_count                  = count;

endmodule

// File: tb/tb_pwm_edge_capture.sv
// Directed bench for pwm_edge_capture: a per-cycle vector table plus hand-built capture scenarios.
// Popped records are collected and compared against hand-computed expected record lists.
module tb_pwm_edge_capture;
    localparam int CH  = 2;
    localparam int TSW = 16;
    localparam int DEP = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [CH-1:0]  pwm_in = '0;
    logic           arm = 1'b0;
    logic           stop = 1'b0;
    logic [TSW-1:0] cap_len = '0;
    logic           rd_ready = 1'b0;
    logic           rd_valid;
    logic [TSW-1:0] rd_ts;
    logic [CH-1:0]  rd_level;
    logic           rd_last;
    logic [$clog2(DEP):0] fifo_count;
    logic           busy;
    logic           done;
    logic           overflow;

    pwm_edge_capture #(.CHANNELS(CH), .TS_WIDTH(TSW), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .arm(arm), .stop(stop),
        .cap_len(cap_len), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_ts(rd_ts),
        .rd_level(rd_level), .rd_last(rd_last), .fifo_count(fifo_count),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int ts; int lvl; int last; } rec_t;
    typedef struct {
        logic          a;
        logic [CH-1:0] p;
        int            exp_count;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    vec_t vec[12];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    logic [CH-1:0] lvl;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs are driven at the falling edge; a head record is logged when it will pop at the next rise.
    task automatic applyStimulus(input logic a, input logic s, input logic [TSW-1:0] len,
                                 input logic [CH-1:0] p, input logic r);
        rec_t rc;
        arm = a; stop = s; cap_len = len; pwm_in = p; rd_ready = r;
        if (rd_valid && rd_ready) begin
            rc.ts = int'(rd_ts); rc.lvl = int'(rd_level); rc.last = int'(rd_last);
            got_q.push_back(rc);
        end
        @(negedge clk);
        if (done) done_seen++;
    endtask

    task automatic addExp(input int ts, input int lv, input int last);
        rec_t rc;
        rc.ts = ts; rc.lvl = lv; rc.last = last;
        exp_q.push_back(rc);
    endtask

    task automatic compareRecords(input string name);
        checkOutput($sformatf("%s record count", name), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checkOutput($sformatf("%s rec%0d ts", name, i), got_q[i].ts, exp_q[i].ts);
                checkOutput($sformatf("%s rec%0d level", name, i), got_q[i].lvl, exp_q[i].lvl);
                checkOutput($sformatf("%s rec%0d last", name, i), got_q[i].last, exp_q[i].last);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec[0]  = '{1'b1, 2'b00, 1, 1'b1, 1'b0};
        for (int k = 1; k <= 4; k++) vec[k] = '{1'b0, 2'b00, 1, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 2'b11, 2, 1'b1, 1'b0};
        vec[6]  = '{1'b0, 2'b10, 3, 1'b1, 1'b0};
        for (int k = 7; k <= 9; k++) vec[k] = '{1'b0, 2'b10, 3, 1'b1, 1'b0};
        vec[10] = '{1'b0, 2'b10, 4, 1'b0, 1'b1};
        vec[11] = '{1'b0, 2'b10, 4, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("reset rd_valid", rd_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset fifo_count", fifo_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-channel capture, cap_len=10, consumer stalled, then drained.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vec[i].a, 1'b0, 16'd10, vec[i].p, 1'b0);
            checkOutput($sformatf("vec%0d fifo_count", i), fifo_count, vec[i].exp_count);
            checkOutput($sformatf("vec%0d busy", i), busy, vec[i].exp_busy);
            checkOutput($sformatf("vec%0d done", i), done, vec[i].exp_done);
            checkOutput($sformatf("vec%0d rd_valid", i), rd_valid, 1);
        end
        checkOutput("vec overflow", overflow, 0);
        repeat (5) applyStimulus(1'b0, 1'b0, 16'd10, 2'b10, 1'b1);
        checkOutput("vec drained count", fifo_count, 0);
        addExp(0, 0, 0); addExp(5, 3, 0); addExp(6, 2, 0); addExp(10, 2, 1);
        compareRecords("two-channel");

        // Single line, cap_len=100, consumer always ready.
        done_seen = 0;
        applyStimulus(1'b1, 1'b0, 16'd100, 2'b00, 1'b1);
        checkOutput("basic busy after arm", busy, 1);
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b0, 1'b0, 16'd100, (k >= 10 && k < 40) ? 2'b01 : 2'b00, 1'b1);
            if (k == 99) checkOutput("basic busy k99", busy, 1);
        end
        checkOutput("basic busy k100", busy, 0);
        checkOutput("basic done k100", done, 1);
        repeat (3) applyStimulus(1'b0, 1'b0, 16'd100, 2'b00, 1'b1);
        checkOutput("basic done pulses", done_seen, 1);
        addExp(0, 0, 0); addExp(10, 1, 0); addExp(40, 0, 0); addExp(100, 0, 1);
        compareRecords("basic");

        // Stalled consumer: the reserved slot keeps the final record.
        lvl = 2'b00;
        applyStimulus(1'b1, 1'b0, 16'd50, lvl, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            if (k == 3 || k == 6 || k == 9 || k == 12) lvl[0] = ~lvl[0];
            applyStimulus(1'b0, 1'b0, 16'd50, lvl, 1'b0);
        end
        checkOutput("full overflow", overflow, 1);
        checkOutput("full fifo_count", fifo_count, 4);
        checkOutput("full busy", busy, 0);
        repeat (6) applyStimulus(1'b0, 1'b0, 16'd50, lvl, 1'b1);
        checkOutput("full drained count", fifo_count, 0);
        checkOutput("full overflow sticky", overflow, 1);
        addExp(0, 0, 0); addExp(3, 1, 0); addExp(6, 0, 0); addExp(50, 0, 1);
        compareRecords("full");

        // Early stop at k=37; a new arm clears overflow.
        done_seen = 0;
        applyStimulus(1'b1, 1'b0, 16'd1000, 2'b01, 1'b1);
        checkOutput("stop overflow cleared", overflow, 0);
        for (int k = 1; k <= 37; k++) applyStimulus(1'b0, k == 37, 16'd1000, 2'b01, 1'b1);
        checkOutput("stop done", done, 1);
        checkOutput("stop busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 16'd1000, 2'b01, 1'b1);
        checkOutput("stop done falls", done, 0);
        applyStimulus(1'b0, 1'b0, 16'd1000, 2'b01, 1'b1);
        checkOutput("stop done pulses", done_seen, 1);
        addExp(0, 1, 0); addExp(37, 1, 1);
        compareRecords("stop");

        // Zero-length capture, then stop in IDLE, then arm ignored during RUN.
        done_seen = 0;
        applyStimulus(1'b1, 1'b0, 16'd0, 2'b10, 1'b1);
        checkOutput("zero busy", busy, 0);
        checkOutput("zero done", done, 1);
        applyStimulus(1'b0, 1'b1, 16'd0, 2'b10, 1'b1);
        checkOutput("zero busy later", busy, 0);
        checkOutput("zero done pulses", done_seen, 1);
        applyStimulus(1'b0, 1'b0, 16'd0, 2'b01, 1'b1);
        checkOutput("idle stop no record", fifo_count, 0);
        addExp(0, 2, 1);
        compareRecords("zero");
        applyStimulus(1'b1, 1'b0, 16'd8, 2'b00, 1'b1);
        for (int k = 1; k <= 8; k++) applyStimulus(k == 3, 1'b0, (k == 3) ? 16'd2 : 16'd8, 2'b00, 1'b1);
        checkOutput("rearm busy", busy, 0);
        checkOutput("rearm done", done, 1);
        repeat (3) applyStimulus(1'b0, 1'b0, 16'd8, 2'b00, 1'b1);
        addExp(0, 0, 0); addExp(8, 0, 1);
        compareRecords("rearm");

        // Reset mid-capture with three records buffered.
        lvl = 2'b00;
        applyStimulus(1'b1, 1'b0, 16'd100, lvl, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            if (k == 5 || k == 10) lvl[0] = ~lvl[0];
            applyStimulus(1'b0, 1'b0, 16'd100, lvl, 1'b0);
        end
        checkOutput("reset-mid buffered", fifo_count, 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset-mid rd_valid", rd_valid, 0);
        checkOutput("reset-mid fifo_count", fifo_count, 0);
        checkOutput("reset-mid busy", busy, 0);
        checkOutput("reset-mid done", done, 0);
        checkOutput("reset-mid overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 16'd100, 2'(k), 1'b1);
        checkOutput("post-reset rd_valid", rd_valid, 0);
        checkOutput("post-reset busy", busy, 0);
        compareRecords("post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
